sipo_deser: RTL and testbench
=============================

// Module: sipo_deser
// PURPOSE
//  Parametrised serial-to-parallel deserialiser; successor to the fixed 144-bit single-lane SIPO.
//  Accepts LANES bits per beat under a valid/ready handshake and assembles WORD_W-bit words.
//  Presents each completed word on a valid/ready output port to the downstream triangle/datapath consumer.
//  Adds backpressure and a synchronous flush; a double-buffer option lets serial input keep flowing.
// PARAMETERS
//  WORD_W     144  assembled word width, bits; must be a multiple of LANES
//  LANES      1    serial bits accepted per beat; 1, 2, 4 or 8
//  MSB_FIRST  1    1: first beat lands in out_data MSBs (shift left); 0: first beat lands in LSBs
// PORTS
//  clk        in   1                 clock, rising edge
//  rst        in   1                 reset rst, asynchronous, active-high
//  flush      in   1                 synchronous abort: discard partial and held words
//  ser_in     in   LANES             serial beat data; ser_in[LANES-1] is the first-in bit when MSB_FIRST=1
//  ser_valid  in   1                 ser_in valid this cycle
//  ser_ready  out  1                 beat accepted when ser_valid && ser_ready
//  out_data   out  WORD_W            assembled word
//  out_valid  out  1                 out_data valid; held until out_ready
//  out_ready  in   1                 downstream accepts when out_valid && out_ready
//  beat_cnt   out  $clog2(BEATS+1)   beats accepted into the current partial word
// BEHAVIOUR
//  BEATS = WORD_W/LANES. An elaboration-time $error fires if WORD_W % LANES != 0.
//  Reset: out_data=0, out_valid=0, ser_ready=1, beat_cnt=0, state=FILL.
//  FSM FILL: ser_ready=1. Each accepted beat shifts LANES bits in and increments beat_cnt.
//   The BEATS-th accepted beat moves the shift register into out_data, sets out_valid=1 and beat_cnt=0.
//   These take effect on the next edge (latency: 1 clk from last beat to out_valid). Next state is HOLD.
//  FSM HOLD: ser_ready=0. out_data/out_valid are stable until out_ready=1.
//   On the handshake: out_valid=0 next cycle, next state FILL.
//   Back-to-back throughput is BEATS+1 cycles per word.
//  flush=1: next cycle beat_cnt=0, out_valid=0, state=FILL, shift register cleared.
//   flush has priority over a coincident beat or output handshake; that beat is dropped.
//  ser_valid=0 mid-word: no shift, no count change; a gap of any length is legal.
//  Arithmetic: beat_cnt wraps BEATS-1 -> 0 only on word completion, never on overflow.
//  Reset mid-word or mid-HOLD: all state returns to reset values asynchronously; the partial word is lost.
//  ser_in is ignored whenever ser_valid=0 or ser_ready=0.
// CONFIGURATION
//  SIPO_DBL_BUF_EN defined: the shift register is independent of the output holding register.
//   ser_ready stays 1 in HOLD while the next word fills.
//   If the next word completes while out_valid=1 && !out_ready, ser_ready drops to 0.
//   It rises again the cycle after the handshake, when the new word transfers into out_data.
//   Completion coinciding with the handshake transfers in the same edge, so out_valid stays 1.
//   Throughput is BEATS cycles per word.
//  SIPO_DBL_BUF_EN undefined: single-buffer behaviour as described in BEHAVIOUR.
// STRUCTURE
//  sipo_pkg: state enum (S_FILL, S_HOLD), function beats(word_w, lanes), lane-width localparams.
//  Sub-module sipo_shift_core: LANES-wide shift register + beat counter + done pulse.
//   Instantiated once; the top level owns the FSM, output register and optional double buffer.
// TESTING
//  WORD_W=144, LANES=1: feed 144 bits 0xA5 pattern, out_ready=1 -> out_valid 1 clk after bit 144, data matches.
//  WORD_W=16, LANES=4, MSB_FIRST=1: beats 0x1,0x2,0x3,0x4 -> out_data=16'h1234; MSB_FIRST=0 -> 16'h4321.
//  out_ready=0 for 10 clks in HOLD -> out_data stable, ser_ready=0 (undef) or 1 until 2nd word done (DBL_BUF).
//  flush after 7 of 16 beats, same cycle as ser_valid -> beat_cnt=0 next clk; next word assembles clean.
//  rst asserted mid-HOLD with out_valid=1 -> out_valid=0 and ser_ready=1 without a clock edge.
//  Random ser_valid gaps (50% duty), out_ready random -> scoreboard: no word lost, reordered or duplicated.

Source files
------------

// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel deserialiser.
// Elaboration helpers keep the beat arithmetic in one place for the core, top and interface.
package sipo_pkg;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } sipo_state_e;

  localparam int unsigned LANES_MIN = 1;
  localparam int unsigned LANES_MAX = 8;

  function automatic int unsigned beats(input int unsigned word_w, input int unsigned lanes);
    return word_w / lanes;
  endfunction

  function automatic bit lanes_ok(input int unsigned lanes);
    return lanes inside {1, 2, 4, 8};
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial-in / word-out bus of sipo_deser; the slave modport is the deserialiser's view.
interface sipo_deser_if #(
  parameter int unsigned WORD_W = 144,
  parameter int unsigned LANES  = 1
);
  import sipo_pkg::*;

  localparam int unsigned BEATS = beats(WORD_W, LANES);
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  logic              flush;
  logic [LANES-1:0]  ser_in;
  logic              ser_valid;
  logic              ser_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  beat_cnt;

  modport master (
    output flush, ser_in, ser_valid, out_ready,
    input  ser_ready, out_data, out_valid, beat_cnt
  );

  modport slave (
    input  flush, ser_in, ser_valid, out_ready,
    output ser_ready, out_data, out_valid, beat_cnt
  );

endinterface

// File: rtl/sipo_deser_shift_core.sv
// LANES-wide shift register with beat counter; done_o flags the beat that completes a word.
// word_o is the register value including the current beat, so the word can be captured on that edge.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter  int unsigned WORD_W    = 144,
  parameter  int unsigned LANES     = 1,
  parameter  bit          MSB_FIRST = 1'b1,
  localparam int unsigned BEATS     = beats(WORD_W, LANES),
  localparam int unsigned CNT_W     = $clog2(BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              shift_en_i,
  input  logic [LANES-1:0]  ser_i,
  output logic [WORD_W-1:0] sr_o,
  output logic [WORD_W-1:0] word_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              done_o
);

  logic [WORD_W-1:0] sr_q, sr_d, shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // MSB-first shifts left and enters at the bottom; LSB-first shifts right and enters at the top.
  always_comb begin
    if (MSB_FIRST) shifted = (sr_q << LANES) | WORD_W'(ser_i);
    else           shifted = (sr_q >> LANES) | (WORD_W'(ser_i) << (WORD_W - LANES));
    done_o = shift_en_i && (cnt_q == CNT_W'(BEATS - 1));
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_en_i) begin
      sr_d  = shifted;
      cnt_d = done_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr_o   = sr_q;
  assign word_o = shifted;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/sipo_deser.sv
// Parametrised SIPO deserialiser: assembles WORD_W-bit words from LANES-bit beats with backpressure.
// Optional feature macro SIPO_DBL_BUF_EN: shift register keeps filling while the output word is held.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WORD_W    = 144,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         rst,
  sipo_deser_if.slave bus
);

  localparam int unsigned BEATS = beats(WORD_W, LANES);
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  if ((WORD_W % LANES) != 0) begin : g_bad_width
    $error("sipo_deser: WORD_W must be a multiple of LANES");
  end
  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("sipo_deser: LANES must be 1, 2, 4 or 8");
  end

  sipo_state_e       state_q, state_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              ser_ready;
  logic              shift_en, done;
  logic [WORD_W-1:0] sr, word;
  logic [CNT_W-1:0]  cnt;

  // flush wins over a coincident beat, so the core never sees that beat
  assign shift_en = bus.ser_valid && ser_ready && !bus.flush;

  sipo_shift_core #(
    .WORD_W    (WORD_W),
    .LANES     (LANES),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (bus.flush),
    .shift_en_i (shift_en),
    .ser_i      (bus.ser_in),
    .sr_o       (sr),
    .word_o     (word),
    .cnt_o      (cnt),
    .done_o     (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      state_d     = S_FILL;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
`ifdef SIPO_DBL_BUF_EN
        // HOLD here means a finished word is parked in the shift register behind a stalled output
        S_FILL: begin
          if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
          if (done) begin
            if (!out_valid_q || bus.out_ready) begin
              out_data_d  = word;
              out_valid_d = 1'b1;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_data_d  = sr;
            out_valid_d = 1'b1;
            state_d     = S_FILL;
          end
        end
`else
        S_FILL: begin
          if (done) begin
            out_data_d  = word;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_FILL;
          end
        end
`endif
        default: state_d = S_FILL;
      endcase
    end
  end

  always_comb begin
    ser_ready = (state_q == S_FILL);
  end

  assign bus.ser_ready = ser_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.beat_cnt  = cnt;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed and scoreboard bench for sipo_deser: 16-bit/4-lane in both bit orders plus 144-bit/1-lane.
// Expectations follow SIPO_DBL_BUF_EN when the bench is built with it.
module tb_sipo_deser;

`ifdef SIPO_DBL_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checkCount = 0;
  int   errCount   = 0;

  sipo_deser_if #(.WORD_W(16),  .LANES(4)) ifm ();
  sipo_deser_if #(.WORD_W(16),  .LANES(4)) ifl ();
  sipo_deser_if #(.WORD_W(144), .LANES(1)) if144 ();

  sipo_deser #(.WORD_W(16),  .LANES(4), .MSB_FIRST(1'b1)) dutM   (.clk(clk), .rst(rst), .bus(ifm));
  sipo_deser #(.WORD_W(16),  .LANES(4), .MSB_FIRST(1'b0)) dutL   (.clk(clk), .rst(rst), .bus(ifl));
  sipo_deser #(.WORD_W(144), .LANES(1), .MSB_FIRST(1'b1)) dut144 (.clk(clk), .rst(rst), .bus(if144));

  // the LSB-first DUT mirrors every input of the MSB-first one
  assign ifl.flush     = ifm.flush;
  assign ifl.ser_in    = ifm.ser_in;
  assign ifl.ser_valid = ifm.ser_valid;
  assign ifl.out_ready = ifm.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] data);
    ifm.ser_valid = valid;
    ifm.ser_in    = data;
    tick();
    ifm.ser_valid = 1'b0;
  endtask

  logic [143:0] pat;
  logic [15:0]  accM, accL;
  int           nb;
  logic [15:0]  qm[$];
  logic [15:0]  ql[$];

  task automatic scoreCycle();
    if (ifm.ser_valid && ifm.ser_ready) begin
      accM = {accM[11:0], ifm.ser_in};
      accL = {ifm.ser_in, accL[15:4]};
      nb++;
      if (nb == 4) begin
        qm.push_back(accM);
        ql.push_back(accL);
        nb = 0;
      end
    end
    if (ifm.out_valid && ifm.out_ready) begin
      if (qm.size() == 0) checkOutput("sb_extra_word", 144'(ifm.out_valid), '0);
      else begin
        checkOutput("sb_msb_word", 144'(ifm.out_data), 144'(qm.pop_front()));
        checkOutput("sb_lsb_word", 144'(ifl.out_data), 144'(ql.pop_front()));
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ifm.flush = 1'b0; ifm.ser_in = '0; ifm.ser_valid = 1'b0; ifm.out_ready = 1'b0;
    if144.flush = 1'b0; if144.ser_in = '0; if144.ser_valid = 1'b0; if144.out_ready = 1'b0;
    pat = {18{8'hA5}};
    accM = '0; accL = '0; nb = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 144'(ifm.out_valid), '0);
    checkOutput("rst_ser_ready", 144'(ifm.ser_ready), 144'(1));
    checkOutput("rst_beat_cnt",  144'(ifm.beat_cnt), '0);
    checkOutput("rst_out_data",  144'(ifm.out_data), '0);
    checkOutput("rst_out_data144", if144.out_data, '0);
    rst = 1'b0;
    tick();

    // basic assembly in both bit orders
    applyStimulus(1'b1, 4'h1);
    applyStimulus(1'b1, 4'h2);
    applyStimulus(1'b1, 4'h3);
    checkOutput("cnt_after3", 144'(ifm.beat_cnt), 144'(3));
    checkOutput("valid_after3", 144'(ifm.out_valid), '0);
    applyStimulus(1'b1, 4'h4);
    checkOutput("valid_after4", 144'(ifm.out_valid), 144'(1));
    checkOutput("msb_word", 144'(ifm.out_data), 144'(16'h1234));
    checkOutput("lsb_word", 144'(ifl.out_data), 144'(16'h4321));
    checkOutput("cnt_wrap", 144'(ifm.beat_cnt), '0);
    checkOutput("ready_in_hold", 144'(ifm.ser_ready), 144'(DBL));

    // backpressure for 10 cycles while beats keep arriving
    for (int i = 0; i < 10; i++) begin
      ifm.ser_valid = 1'b1;
      ifm.ser_in    = 4'(5 + i);
      tick();
      checkOutput("hold_data_stable", 144'(ifm.out_data), 144'(16'h1234));
      if (i == 1) checkOutput("ready_mid_hold", 144'(ifm.ser_ready), 144'(DBL));
    end
    ifm.ser_valid = 1'b0;
    checkOutput("ready_end_hold", 144'(ifm.ser_ready), '0);
    checkOutput("valid_end_hold", 144'(ifm.out_valid), 144'(1));

    ifm.out_ready = 1'b1;
    tick();
    checkOutput("valid_after_hs", 144'(ifm.out_valid), 144'(DBL));
    checkOutput("ready_after_hs", 144'(ifm.ser_ready), 144'(1));
    if (DBL) begin
      checkOutput("dbl_msb_word2", 144'(ifm.out_data), 144'(16'h5678));
      checkOutput("dbl_lsb_word2", 144'(ifl.out_data), 144'(16'h8765));
    end
    tick();
    ifm.out_ready = 1'b0;
    checkOutput("valid_drained", 144'(ifm.out_valid), '0);
    checkOutput("cnt_drained", 144'(ifm.beat_cnt), '0);

    // flush coinciding with a beat drops it; next word is clean
    applyStimulus(1'b1, 4'h9);
    applyStimulus(1'b1, 4'h9);
    applyStimulus(1'b1, 4'h9);
    ifm.flush = 1'b1;
    applyStimulus(1'b1, 4'hF);
    ifm.flush = 1'b0;
    checkOutput("flush_cnt", 144'(ifm.beat_cnt), '0);
    checkOutput("flush_valid", 144'(ifm.out_valid), '0);
    applyStimulus(1'b1, 4'h1);
    applyStimulus(1'b1, 4'h2);
    applyStimulus(1'b1, 4'h3);
    applyStimulus(1'b1, 4'h4);
    checkOutput("post_flush_msb", 144'(ifm.out_data), 144'(16'h1234));
    checkOutput("post_flush_lsb", 144'(ifl.out_data), 144'(16'h4321));
    ifm.flush = 1'b1;
    tick();
    ifm.flush = 1'b0;
    checkOutput("flush_hold_valid", 144'(ifm.out_valid), '0);
    checkOutput("flush_hold_ready", 144'(ifm.ser_ready), 144'(1));

    // idle gaps between beats
    applyStimulus(1'b1, 4'hA);
    repeat (3) applyStimulus(1'b0, 4'hE);
    checkOutput("gap_cnt", 144'(ifm.beat_cnt), 144'(1));
    applyStimulus(1'b1, 4'hB);
    applyStimulus(1'b0, 4'h7);
    applyStimulus(1'b1, 4'hC);
    applyStimulus(1'b1, 4'hD);
    checkOutput("gap_word", 144'(ifm.out_data), 144'(16'hABCD));
    checkOutput("gap_valid", 144'(ifm.out_valid), 144'(1));

    // asynchronous reset while holding a word
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", 144'(ifm.out_valid), '0);
    checkOutput("arst_ready", 144'(ifm.ser_ready), 144'(1));
    checkOutput("arst_data", 144'(ifm.out_data), '0);
    #1 rst = 1'b0;
    tick();

    // 144-bit single lane, 0xA5 pattern, first bit is the MSB
    if144.out_ready = 1'b1;
    for (int b = 0; b < 144; b++) begin
      if144.ser_valid = 1'b1;
      if144.ser_in    = pat[143-b];
      tick();
      if (b == 142) begin
        checkOutput("w144_cnt143", 144'(if144.beat_cnt), 144'(143));
        checkOutput("w144_valid_early", 144'(if144.out_valid), '0);
      end
    end
    if144.ser_valid = 1'b0;
    checkOutput("w144_valid", 144'(if144.out_valid), 144'(1));
    checkOutput("w144_data", if144.out_data, pat);
    tick();
    checkOutput("w144_consumed", 144'(if144.out_valid), '0);

    // random gaps and backpressure against a queue of expected words
    for (int c = 0; c < 600; c++) begin
      ifm.ser_valid = 1'($urandom_range(0, 1));
      ifm.ser_in    = 4'($urandom_range(0, 15));
      ifm.out_ready = 1'($urandom_range(0, 1));
      scoreCycle();
    end
    ifm.ser_valid = 1'b0;
    ifm.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) scoreCycle();
    checkOutput("sb_words_left", 144'(qm.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
